// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/RAM arbiter: RAM handshake states, data words,
// arbiter FSM states and an index-width helper.
package cache_mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } arb_state_t;

  // Width of a CPU index; a single CPU still gets a 1-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Cache-control bus: per-CPU icache/dcache request ports plus the single RAM port.
interface cache_mem_arbiter_if #(parameter int CPUS = 2);
  import cache_mem_arbiter_pkg::*;

  logic [CPUS-1:0]  iREN;
  logic [CPUS-1:0]  dREN;
  logic [CPUS-1:0]  dWEN;
  logic [CPUS-1:0]  iwait;
  logic [CPUS-1:0]  dwait;
  word_t [CPUS-1:0] iaddr;
  word_t [CPUS-1:0] daddr;
  word_t [CPUS-1:0] dstore;
  word_t [CPUS-1:0] iload;
  word_t [CPUS-1:0] dload;
  logic             ramREN;
  logic             ramWEN;
  word_t            ramaddr;
  word_t            ramstore;
  word_t            ramload;
  ramstate_t        ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/cache_mem_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after ptr, wrapping.
module cache_mem_arbiter_rr_picker #(
  parameter int CPUS = 2,
  parameter int CW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0] req,
  input  logic [CW-1:0]   ptr,
  output logic [CW-1:0]   idx,
  output logic            valid
);

  // Walk offsets from the far end so the nearest requester overwrites the rest.
  always_comb begin
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      cand  = (int'(ptr) + k) % CPUS;
      valid = valid | req[cand];
      idx   = req[cand] ? CW'(cand) : idx;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache requests of all CPUs onto one RAM port, holding a
// dcache grant across a BURST-word block so blocks never interleave.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int CPUS  = 2,
  parameter int BURST = 2
) (
  input logic CLK,
  input logic nRST,
  cache_mem_arbiter_if.slave bus
);

  localparam int CW = idx_w(CPUS);
  localparam int BW = $clog2(BURST + 1);

  arb_state_t       state;
  logic [CW-1:0]    grant_cpu;
  logic             grant_d;
  logic [CW-1:0]    rr_ptr;
  logic [BW-1:0]    burst_cnt;
  word_t [CPUS-1:0] iload_r;
  word_t [CPUS-1:0] dload_r;

  logic [CPUS-1:0]  dreq_s;
  logic [CW-1:0]    d_idx_s;
  logic [CW-1:0]    i_idx_s;
  logic             d_vld_s;
  logic             i_vld_s;
  logic             g_req_s;
  logic             g_wen_s;
  logic             serve_s;
  logic             access_s;
  logic [CW-1:0]    next_ptr_s;
  logic [CPUS-1:0]  iwait_s;
  logic [CPUS-1:0]  dwait_s;
  word_t [CPUS-1:0] iload_s;
  word_t [CPUS-1:0] dload_s;

  assign dreq_s = bus.dREN | bus.dWEN;

  cache_mem_arbiter_rr_picker #(.CPUS(CPUS), .CW(CW)) u_pick_d (
    .req(dreq_s), .ptr(rr_ptr), .idx(d_idx_s), .valid(d_vld_s)
  );

  cache_mem_arbiter_rr_picker #(.CPUS(CPUS), .CW(CW)) u_pick_i (
    .req(bus.iREN), .ptr(rr_ptr), .idx(i_idx_s), .valid(i_vld_s)
  );

  // Granted-master view: request still held, write vs read, RAM completion.
  always_comb begin
    g_req_s    = grant_d ? dreq_s[grant_cpu] : bus.iREN[grant_cpu];
    g_wen_s    = grant_d & bus.dWEN[grant_cpu];
    serve_s    = (state == SERVE) && g_req_s;
    access_s   = serve_s && (bus.ramstate == ACCESS);
    next_ptr_s = (int'(grant_cpu) + 1 >= CPUS) ? '0 : grant_cpu + CW'(1);
  end

  // RAM strobes and per-port wait/load; only the granted port completes.
  always_comb begin
    bus.ramREN   = serve_s && !g_wen_s;
    bus.ramWEN   = serve_s && g_wen_s;
    bus.ramaddr  = serve_s ? (grant_d ? bus.daddr[grant_cpu] : bus.iaddr[grant_cpu]) : 32'h0000_0000;
    bus.ramstore = (serve_s && g_wen_s) ? bus.dstore[grant_cpu] : 32'h0000_0000;
    iwait_s = '1;
    dwait_s = '1;
    iload_s = iload_r;
    dload_s = dload_r;
    for (int c = 0; c < CPUS; c++) begin
      iwait_s[c] = !(access_s && !grant_d && (grant_cpu == CW'(c)));
      dwait_s[c] = !(access_s && grant_d && (grant_cpu == CW'(c)));
      iload_s[c] = !iwait_s[c] ? bus.ramload : iload_r[c];
      dload_s[c] = (!dwait_s[c] && !g_wen_s) ? bus.ramload : dload_r[c];
    end
  end

  assign bus.iwait = iwait_s;
  assign bus.dwait = dwait_s;
  assign bus.iload = iload_s;
  assign bus.dload = dload_s;

  // Arbiter FSM with grant, fairness pointer, burst count and held load data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      grant_cpu <= '0;
      grant_d   <= 1'b0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      iload_r   <= '0;
      dload_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_vld_s) begin
            grant_cpu <= d_idx_s;
            grant_d   <= 1'b1;
            burst_cnt <= '0;
            state     <= SERVE;
          end else if (i_vld_s) begin
            grant_cpu <= i_idx_s;
            grant_d   <= 1'b0;
            burst_cnt <= '0;
            state     <= SERVE;
          end else begin
            state <= IDLE;
          end
        end
        SERVE: begin
          if (!g_req_s) begin
            state <= IDLE;
          end else if (bus.ramstate == ACCESS) begin
            if (!grant_d) begin
              iload_r[grant_cpu] <= bus.ramload;
            end else if (!g_wen_s) begin
              dload_r[grant_cpu] <= bus.ramload;
            end else begin
              dload_r <= dload_r;
            end
            if (grant_d && (int'(burst_cnt) + 1 < BURST)) begin
              burst_cnt <= burst_cnt + BW'(1);
              state     <= HOLD;
            end else begin
              rr_ptr <= next_ptr_s;
              state  <= IDLE;
            end
          end else begin
            state <= SERVE;
          end
        end
        HOLD: begin
          if (grant_d && dreq_s[grant_cpu]) begin
            state <= SERVE;
          end else begin
            rr_ptr <= next_ptr_s;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed cache traffic against a
// latency-programmable RAM model; a monitor checks every completed access.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int CPUS = 2;

  typedef struct {
    int          cpu;
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic CLK = 1'b0;
  logic nRST;
  int   passed = 0;
  int   total  = 0;
  int   lat    = 0;
  int   cnt    = 0;
  bit   err_mode = 1'b0;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  cache_mem_arbiter_if #(.CPUS(CPUS)) bus ();

  cache_mem_arbiter #(.CPUS(CPUS), .BURST(2)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  // RAM model: BUSY (or ERROR) for lat cycles of a held strobe, then ACCESS.
  always @(posedge CLK) begin
    if ((bus.ramREN || bus.ramWEN) && bus.ramstate != ACCESS) cnt <= cnt + 1;
    else cnt <= 0;
  end

  always_comb begin
    if (!(bus.ramREN || bus.ramWEN)) bus.ramstate = FREE;
    else if (cnt >= lat) bus.ramstate = ACCESS;
    else bus.ramstate = err_mode ? ERROR : BUSY;
    bus.ramload = (bus.ramaddr == 32'h0000_0100) ? 32'hDEAD_BEEF : bus.ramaddr + 32'h1000_0000;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic push(input int cpu, input bit is_d, input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.cpu = cpu; e.is_d = is_d; e.we = we; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: every wait that drops must match the next expected response.
  initial begin
    exp_t e;
    bit   w;
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1) begin
        for (int c = 0; c < CPUS; c++) begin
          for (int d = 0; d < 2; d++) begin
            w = (d == 1) ? bus.dwait[c] : bus.iwait[c];
            if (!w) begin
              if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_resp: cpu %0d dcache %0d completed, required none", c, d);
              end else begin
                e = sb.pop_front();
                chk("resp_cpu", 32'(c), 32'(e.cpu));
                chk("resp_kind", 32'(d), 32'(e.is_d));
                chk("resp_ramaddr", bus.ramaddr, e.addr);
                chk("resp_ramWEN", 32'(bus.ramWEN), 32'(e.we));
                chk("resp_ramREN", 32'(bus.ramREN), 32'(!e.we));
                if (e.we) chk("resp_ramstore", bus.ramstore, e.data);
                else chk("resp_load", (d == 1) ? bus.dload[c] : bus.iload[c], e.data);
              end
            end
          end
        end
      end
    end
  end

  task automatic wait_ack(input int c, input bit is_d, output int n);
    bit w;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      w = is_d ? bus.dwait[c] : bus.iwait[c];
    end while (w && n < 200);
    if (w) begin
      total++;
      $display("FAIL timeout_ack: cpu %0d dcache %0d still waiting after %0d cycles, required ack", c, is_d, n);
    end
  endtask

  task automatic icache_read(input int c, input logic [31:0] a, output int n);
    bus.iREN[c]  = 1'b1;
    bus.iaddr[c] = a;
    wait_ack(c, 1'b0, n);
    @(posedge CLK); #1;
    bus.iREN[c] = 1'b0;
  endtask

  task automatic dcache_reads(input int c, input logic [31:0] base, input int words);
    int n;
    bus.dREN[c] = 1'b1;
    for (int k = 0; k < words; k++) begin
      bus.daddr[c] = base + 32'(4 * k);
      wait_ack(c, 1'b1, n);
      @(posedge CLK); #1;
    end
    bus.dREN[c] = 1'b0;
  endtask

  task automatic dcache_write2(input int c, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [31:0] d1);
    int n;
    bus.dWEN[c] = 1'b1;
    bus.daddr[c] = a0; bus.dstore[c] = d0;
    wait_ack(c, 1'b1, n);
    @(posedge CLK); #1;
    bus.daddr[c] = a1; bus.dstore[c] = d1;
    wait_ack(c, 1'b1, n);
    @(posedge CLK); #1;
    bus.dWEN[c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    nRST = 1'b0;
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_iwait", 32'(bus.iwait), 32'h3);
    chk("reset_dwait", 32'(bus.dwait), 32'h3);
    chk("reset_iload0", bus.iload[0], 32'h0);
    chk("reset_dload1", bus.dload[1], 32'h0);
    chk("reset_strobes", {30'h0, bus.ramREN, bus.ramWEN}, 32'h0);
    chk("reset_ramaddr", bus.ramaddr, 32'h0);
    chk("reset_ramstore", bus.ramstore, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Reset during a write: strobe must fall immediately.
    lat = 100;
    bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h0000_0050; bus.dstore[1] = 32'h0000_0077;
    k = 0;
    do begin @(negedge CLK); k++; end while (!bus.ramWEN && k < 10);
    chk("rst_mid_wen_before", 32'(bus.ramWEN), 32'h1);
    #2 nRST = 1'b0;
    #1;
    chk("rst_mid_wen_after", 32'(bus.ramWEN), 32'h0);
    chk("rst_mid_ren_after", 32'(bus.ramREN), 32'h0);
    chk("rst_mid_dwait", 32'(bus.dwait), 32'h3);
    chk("rst_mid_iwait", 32'(bus.iwait), 32'h3);
    chk("rst_mid_dload", bus.dload[1], 32'h0);
    bus.dWEN[1] = 1'b0;
    lat = 0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // Round-robin between two streaming dcaches, two-word bursts each.
    push(0, 1, 0, 32'h0000_0400, 32'h1000_0400);
    push(0, 1, 0, 32'h0000_0404, 32'h1000_0404);
    push(1, 1, 0, 32'h0000_0500, 32'h1000_0500);
    push(1, 1, 0, 32'h0000_0504, 32'h1000_0504);
    push(0, 1, 0, 32'h0000_0408, 32'h1000_0408);
    push(0, 1, 0, 32'h0000_040C, 32'h1000_040C);
    fork
      dcache_reads(0, 32'h0000_0400, 4);
      dcache_reads(1, 32'h0000_0500, 2);
    join
    repeat (2) @(posedge CLK); #1;

    // Single icache read, two BUSY cycles before ACCESS.
    lat = 2;
    push(0, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF);
    fork
      icache_read(0, 32'h0000_0100, n);
      begin
        @(negedge CLK); @(negedge CLK);
        chk("iread_busy_ren", 32'(bus.ramREN), 32'h1);
        chk("iread_busy_addr", bus.ramaddr, 32'h0000_0100);
        chk("iread_busy_iwait", 32'(bus.iwait[0]), 32'h1);
      end
    join
    chk("iread_latency", 32'(n), 32'd4);
    @(negedge CLK);
    chk("iread_load_held", bus.iload[0], 32'hDEAD_BEEF);
    @(posedge CLK); #1;

    // Dcache beats icache of the same CPU; RAM reports ERROR while pending.
    lat = 1; err_mode = 1'b1;
    push(0, 1, 0, 32'h0000_0200, 32'h1000_0200);
    push(0, 0, 0, 32'h0000_0104, 32'h1000_0104);
    fork
      dcache_reads(0, 32'h0000_0200, 1);
      icache_read(0, 32'h0000_0104, n);
    join
    err_mode = 1'b0; lat = 0;
    repeat (2) @(posedge CLK); #1;

    // Two-word write-back holds the grant against a pending icache read.
    push(1, 1, 1, 32'h0000_3100, 32'h0000_0011);
    push(1, 1, 1, 32'h0000_3104, 32'h0000_0022);
    push(0, 0, 0, 32'h0000_0108, 32'h1000_0108);
    fork
      dcache_write2(1, 32'h0000_3100, 32'h0000_0011, 32'h0000_3104, 32'h0000_0022);
      icache_read(0, 32'h0000_0108, n);
    join
    repeat (2) @(posedge CLK); #1;

    // Abort: granted dcache drops its read while RAM is busy.
    lat = 100;
    bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h0000_0600;
    @(negedge CLK); @(negedge CLK);
    chk("abort_ren_before", 32'(bus.ramREN), 32'h1);
    @(posedge CLK); #1;
    bus.dREN[1] = 1'b0;
    @(negedge CLK);
    chk("abort_ren_same_cycle", 32'(bus.ramREN), 32'h0);
    chk("abort_dwait", 32'(bus.dwait), 32'h3);
    @(negedge CLK);
    chk("abort_state_idle", 32'(dut.state), 32'(IDLE));
    chk("abort_rr_ptr", 32'(dut.rr_ptr), 32'h1);
    lat = 0;

    repeat (4) @(posedge CLK);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Responder end of the cache-control protocol. Serves the icache and dcache of every CPU: iREN/dREN/dWEN with address/store in, iwait/dwait with load data out.
- Arbitrates those requests onto the single RAM port (ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate).
- Holds a dcache grant across a two-word block transfer (fetch1/fetch2, wb1/wb2, flush pairs), so a block never interleaves with another master.

Parameters:
CPUS, 2, number of CPUs (each has one icache and one dcache port)
BURST, 2, max words a dcache grant may be held back-to-back (block size in words)

Ports:
CLK  in  1  clock
nRST  in  1  reset; one clock; asynchronous, active-low
iREN  in  CPUS  icache read request per CPU
iaddr  in  CPUS x 32  icache word address
dREN  in  CPUS  dcache read request
dWEN  in  CPUS  dcache write request
daddr  in  CPUS x 32  dcache word address
dstore  in  CPUS x 32  dcache write data
iwait  out  CPUS  1 = icache must hold request
dwait  out  CPUS  1 = dcache must hold request
iload  out  CPUS x 32  icache read data, valid when iwait=0
dload  out  CPUS x 32  dcache read data, valid when dwait=0
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset (async, nRST=0): state=IDLE, grant cleared, rr_ptr=0, burst_cnt=0. All iwait/dwait=1, iload/dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0. Reset mid-transaction drops the RAM strobes immediately, with no completion.
- Master encoding: {cpu index, is_dcache}. A dcache request is dREN|dWEN. Within one CPU, dcache beats icache. Across CPUs, round-robin starting at rr_ptr.
- States:
  - IDLE: no RAM strobes. If any request is pending, register the winner into grant, set burst_cnt=0, go to SERVE. Otherwise stay.
  - SERVE: drive RAM combinationally from the granted master only.
    - Granted dcache with dWEN=1: ramWEN=1, ramREN=0, ramstore=dstore (write wins over simultaneous dREN).
    - Granted dcache with dREN only, or granted icache: ramREN=1. ramaddr=granted address.
  - SERVE on ramstate=ACCESS:
    - Same cycle, granted master's wait=0 and its load=ramload (reads).
    - Dcache grant with burst_cnt+1<BURST: go to HOLD, burst_cnt++.
    - Otherwise: rr_ptr=(granted cpu+1) mod CPUS, go to IDLE.
  - SERVE on BUSY/FREE/ERROR: wait stays 1, remain in SERVE. ERROR is retried indefinitely, never reported.
  - SERVE when the granted master drops its request: abort. Strobes fall that cycle, go to IDLE, rr_ptr unchanged.
  - HOLD (one cycle, no strobes): if the same dcache still requests, go to SERVE with the same grant (burst continuation). Else advance rr_ptr, go to IDLE.
- Every wait not belonging to the current ACCESS cycle is 1. Load outputs of non-granted masters keep their last value.
- Latency: request seen in cycle 0 → strobes in cycle 1 → earliest wait=0 in cycle 1 (zero-latency RAM). A two-word block with zero-latency RAM completes in cycles 1 and 3.
- Max wait is bounded: round-robin plus the BURST cap prevent starvation.

Decomposition:
- cpu_types_pkg (existing): ramstate_t, word_t. Add arb_state_t {IDLE, SERVE, HOLD} there.
- One sub-module, rr_picker: combinational CPUS-wide round-robin select (request vector, rr_ptr → winner index, valid), instantiated twice (dcache requests, then icache requests when no dcache request).

Test Plan:
- Reset: nRST low mid-SERVE with ramWEN=1 → ramWEN=0 same cycle, all waits=1, loads=0.
- Single icache read: CPU0 iREN, iaddr=0x100, RAM ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF → ramREN=1 with ramaddr=0x100; iwait[0]=0 with iload[0]=0xDEADBEEF exactly on the ACCESS cycle.
- Dcache over icache: CPU0 iREN and dREN together, daddr=0x200 → dcache served first; icache served after the dcache burst ends.
- Block burst: CPU1 dWEN at 0x3100 then 0x3104 with dstore 0x11/0x22, while CPU0 iREN is pending → both words written back-to-back via HOLD, no icache access interleaved; then CPU0 is served.
- Round-robin: both CPUs issue continuous dREN → grants alternate CPU0, CPU1, CPU0 per completed burst.
- Abort: granted dcache deasserts dREN while ramstate=BUSY → ramREN falls that cycle, FSM in IDLE next cycle, rr_ptr unchanged.
